// File: rtl/da_seq_if.sv
// da_seq_ctrl bus: sample handshake, DA
// delay-line/bit-slice drive and result handshake.
interface da_seq_if;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  x1;
    logic [7:0]  x2;
    logic [7:0]  x3;
    logic [7:0]  x4;
    logic [2:0]  t;
    logic        mac_clr;
    logic [9:0]  su;
    logic [9:0]  ca;
    logic [10:0] y;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    modport master (
        output flush, in_valid, in_data,
        output su, ca, out_ready,
        input  in_ready, x1, x2, x3, x4,
        input  t, mac_clr, y, out_valid, busy
    );

    modport slave (
        input  flush, in_valid, in_data,
        input  su, ca, out_ready,
        output in_ready, x1, x2, x3, x4,
        output t, mac_clr, y, out_valid, busy
    );
endinterface

// File: rtl/da_seq_ctrl.sv
// Bit-serial DA filter sequencer: delay line,
// 8 bit-slice steps, carry-save resolve to y.
module da_seq_ctrl (
    input  logic  clk,
    input  logic  r,
    da_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAP,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [7:0]  x1_q;
    logic [7:0]  x2_q;
    logic [7:0]  x3_q;
    logic [7:0]  x4_q;
    logic [10:0] y_q;
    logic        ov_q;
    logic        in_rdy;
    logic        accept;
    logic [10:0] sum;

    assign in_rdy = (state_q == IDLE) && r;
    assign accept = bus.in_valid && in_rdy;
    assign sum    = {bus.su[9], bus.su}
                  + {bus.ca[9], bus.ca};

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (cnt_q == 3'd7) state_d = CAP;
            CAP:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, delay line, bit counter and result.
    always_ff @(posedge clk) begin
        if (!r) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            x1_q    <= 8'd0;
            x2_q    <= 8'd0;
            x3_q    <= 8'd0;
            x4_q    <= 8'd0;
            y_q     <= 11'd0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        x4_q  <= x3_q;
                        x3_q  <= x2_q;
                        x2_q  <= x1_q;
                        x1_q  <= bus.in_data;
                        cnt_q <= 3'd0;
                    end else if (bus.flush) begin
                        x1_q <= 8'd0;
                        x2_q <= 8'd0;
                        x3_q <= 8'd0;
                        x4_q <= 8'd0;
                    end
                end
                RUN: cnt_q <= cnt_q + 3'd1;
                CAP: begin
                    y_q  <= sum;
                    ov_q <= 1'b1;
                end
                DONE: if (bus.out_ready) ov_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Decoded outputs.
    always_comb begin
        bus.in_ready  = in_rdy;
        bus.x1        = x1_q;
        bus.x2        = x2_q;
        bus.x3        = x3_q;
        bus.x4        = x4_q;
        bus.y         = y_q;
        bus.out_valid = ov_q;
        bus.t         = 3'd0;
        if (state_q == RUN) bus.t = cnt_q;
        bus.mac_clr   = (state_q == IDLE)
                     || (state_q == DONE);
        bus.busy      = (state_q == RUN)
                     || (state_q == CAP);
    end
endmodule

// File: tb/tb_da_seq_ctrl.sv
// Self-checking bench for da_seq_ctrl with a
// behavioural delay-line / resolve model.
module tb_da_seq_ctrl;
    logic clk = 1'b0;
    logic r   = 1'b0;
    int checks   = 0;
    int failures = 0;

    int mx [4];

    da_seq_if bus ();

    da_seq_ctrl dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_sc();
        bus.su = 10'($urandom);
        bus.ca = 10'($urandom);
    endtask

    task automatic chk_x(input string tag);
        chk({tag, "_x1"}, 16'(bus.x1), 16'(mx[0]));
        chk({tag, "_x2"}, 16'(bus.x2), 16'(mx[1]));
        chk({tag, "_x3"}, 16'(bus.x3), 16'(mx[2]));
        chk({tag, "_x4"}, 16'(bus.x4), 16'(mx[3]));
    endtask

    function automatic int resolve(int s, int c);
        int sv;
        int cv;
        sv = (s >= 512) ? s - 1024 : s;
        cv = (c >= 512) ? c - 1024 : c;
        return (sv + cv) & 2047;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mx[i] = 0;
    endtask

    // One full sample; hold = DONE wait cycles.
    task automatic run_sample(input int d,
                              input int s,
                              input int c,
                              input int hold,
                              input bit fl);
        int ey;
        chk("idle_rdy", 16'(bus.in_ready), 16'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
        bus.flush    = fl;
        step();
        bus.in_valid = $urandom_range(0, 1) == 1;
        bus.in_data  = 8'($urandom);
        bus.flush    = $urandom_range(0, 1) == 1;
        for (int i = 3; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = d;
        for (int k = 0; k < 8; k++) begin
            chk("run_t", 16'(bus.t), 16'(k));
            chk("run_clr", 16'(bus.mac_clr), 16'd0);
            chk("run_busy", 16'(bus.busy), 16'd1);
            chk("run_rdy", 16'(bus.in_ready), 16'd0);
            rnd_sc();
            step();
        end
        chk("cap_busy", 16'(bus.busy), 16'd1);
        chk("cap_t", 16'(bus.t), 16'd0);
        chk("cap_ov", 16'(bus.out_valid), 16'd0);
        chk_x("cap");
        bus.su = 10'(s);
        bus.ca = 10'(c);
        bus.out_ready = (hold == 0);
        step();
        ey = resolve(s, c);
        rnd_sc();
        bus.in_valid = 1'b1;
        chk("done_ov", 16'(bus.out_valid), 16'd1);
        chk("done_y", 16'(bus.y), 16'(ey));
        chk("done_busy", 16'(bus.busy), 16'd0);
        chk("done_clr", 16'(bus.mac_clr), 16'd1);
        for (int h = 0; h < hold; h++) begin
            step();
            rnd_sc();
            bus.in_data = 8'($urandom);
            chk("bp_ov", 16'(bus.out_valid), 16'd1);
            chk("bp_y", 16'(bus.y), 16'(ey));
            chk("bp_rdy", 16'(bus.in_ready), 16'd0);
            chk_x("bp");
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        chk("ho_ov", 16'(bus.out_valid), 16'd0);
        chk("ho_rdy", 16'(bus.in_ready), 16'd1);
        chk("ho_y", 16'(bus.y), 16'(ey));
        chk_x("ho");
    endtask

    initial begin
        int d;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        rnd_sc();
        clear_model();

        // Power-on reset.
        repeat (3) step();
        chk("rst_y", 16'(bus.y), 16'd0);
        chk("rst_ov", 16'(bus.out_valid), 16'd0);
        chk("rst_t", 16'(bus.t), 16'd0);
        chk("rst_clr", 16'(bus.mac_clr), 16'd1);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_rdy", 16'(bus.in_ready), 16'd0);
        chk_x("rst");
        r = 1'b1;
        step();
        chk("rst_rdy1", 16'(bus.in_ready), 16'd1);

        // Single sample, no back-pressure.
        run_sample(8'h05, 10'h3FF, 10'h001, 0, 0);

        // Delay line ordering.
        for (int i = 1; i <= 4; i++)
            run_sample(i, $urandom_range(0, 1023),
                       $urandom_range(0, 1023), 0, 0);
        chk_x("dl");

        // Flush in IDLE.
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        clear_model();
        chk_x("flush");

        // Refill, then flush together with valid.
        for (int i = 0; i < 3; i++)
            run_sample($urandom_range(0, 255), 0, 0, 0, 0);
        run_sample(8'hA7, 0, 0, 0, 1);

        // Arithmetic corners.
        run_sample(8'h11, 10'h1FF, 10'h1FF, 0, 0);
        run_sample(8'h22, 10'h200, 10'h200, 0, 0);

        // Back-pressure.
        run_sample(8'h5A, 10'h155, 10'h0F3, 6, 0);

        // Random samples and DA values.
        for (int n = 0; n < 6; n++)
            run_sample($urandom_range(0, 255),
                       $urandom_range(0, 1023),
                       $urandom_range(0, 1023),
                       $urandom_range(0, 3), 0);

        // Reset from a DONE wait.
        run_sample(8'h33, 10'h010, 10'h020, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h44;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        chk("pre_ov", 16'(bus.out_valid), 16'd1);
        r = 1'b0;
        repeat (3) step();
        clear_model();
        chk("rst2_y", 16'(bus.y), 16'd0);
        chk("rst2_ov", 16'(bus.out_valid), 16'd0);
        chk("rst2_clr", 16'(bus.mac_clr), 16'd1);
        chk("rst2_rdy", 16'(bus.in_ready), 16'd0);
        chk_x("rst2");
        r = 1'b1;
        step();
        chk("rst2_rdy1", 16'(bus.in_ready), 16'd1);

        // Mid-RUN reset at t = 4.
        d = $urandom_range(1, 255);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("mid_t4", 16'(bus.t), 16'd4);
        chk("mid_x1", 16'(bus.x1), 16'(d));
        r = 1'b0;
        step();
        r = 1'b1;
        chk("mid_t", 16'(bus.t), 16'd0);
        chk("mid_busy", 16'(bus.busy), 16'd0);
        chk("mid_clr", 16'(bus.mac_clr), 16'd1);
        chk_x("mid");
        for (int k = 0; k < 14; k++) begin
            step();
            chk("mid_noov", 16'(bus.out_valid), 16'd0);
        end
        chk("mid_y", 16'(bus.y), 16'd0);

        // Delay line resumes cleanly after reset.
        run_sample(8'hC3, 10'h2AA, 10'h155, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
